// File: rtl/icache_ctrl_if.sv
// Fetch, cache-array and instruction-memory signals of the icache miss/fill controller.
// master: the controller; slave: fetch stage, storage array and memory seen as one peer.
interface icache_ctrl_if #(
  parameter int unsigned INDEX_W   = 5,
  parameter int unsigned TAG_W     = 8,
  parameter int unsigned MEM_TAG_W = 4
) ();
  logic [63:0]          proc2Icache_addr;
  logic [63:0]          Icache_data_out;
  logic                 Icache_valid_out;
  logic [INDEX_W-1:0]   cache_rd_idx;
  logic [TAG_W-1:0]     cache_rd_tag;
  logic                 cache_rd_valid;
  logic [63:0]          cache_rd_data;
  logic                 cache_wr_en;
  logic [INDEX_W-1:0]   cache_wr_idx;
  logic [TAG_W-1:0]     cache_wr_tag;
  logic [63:0]          cache_wr_data;
  logic [1:0]           proc2Imem_command;
  logic [63:0]          proc2Imem_addr;
  logic [MEM_TAG_W-1:0] Imem2proc_response;
  logic [MEM_TAG_W-1:0] Imem2proc_tag;
  logic [63:0]          Imem2proc_data;

  modport master (
    input  proc2Icache_addr, cache_rd_valid, cache_rd_data,
    input  Imem2proc_response, Imem2proc_tag, Imem2proc_data,
    output Icache_data_out, Icache_valid_out, cache_rd_idx, cache_rd_tag,
    output cache_wr_en, cache_wr_idx, cache_wr_tag, cache_wr_data,
    output proc2Imem_command, proc2Imem_addr
  );

  modport slave (
    output proc2Icache_addr, cache_rd_valid, cache_rd_data,
    output Imem2proc_response, Imem2proc_tag, Imem2proc_data,
    input  Icache_data_out, Icache_valid_out, cache_rd_idx, cache_rd_tag,
    input  cache_wr_en, cache_wr_idx, cache_wr_tag, cache_wr_data,
    input  proc2Imem_command, proc2Imem_addr
  );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped icache miss/fill controller: one outstanding demand load, fill with forwarding.
// Define ICACHE_PREFETCH_EN to add a next-line prefetch after every demand fill.
module icache_ctrl #(
  parameter int unsigned INDEX_W   = 5,
  parameter int unsigned TAG_W     = 8,
  parameter int unsigned MEM_TAG_W = 4
) (
  input logic           clock,
  input logic           reset,
  icache_ctrl_if.master bus
);

  localparam logic [1:0] BusNone = 2'd0;
  localparam logic [1:0] BusLoad = 2'd1;

`ifdef ICACHE_PREFETCH_EN
  typedef enum logic [1:0] {StIdle, StWait, StPfReq, StPfWait} state_e;
`else
  typedef enum logic {StIdle, StWait} state_e;
`endif

  state_e               state_q, state_d;
  logic [63:0]          miss_addr_q, miss_addr_d;
  logic [MEM_TAG_W-1:0] pend_tag_q, pend_tag_d;

  logic [63:0] pc_line;
  logic        fill_hit;
  logic        fwd;

  assign pc_line  = bus.proc2Icache_addr & ~64'h7;
  // Tag 0 means "no data", so it can never complete a fill.
  assign fill_hit = (bus.Imem2proc_tag == pend_tag_q) && (bus.Imem2proc_tag != '0);
  assign fwd      = fill_hit && (pc_line == miss_addr_q);

  assign bus.cache_rd_idx = bus.proc2Icache_addr[3 +: INDEX_W];
  assign bus.cache_rd_tag = bus.proc2Icache_addr[3 + INDEX_W +: TAG_W];

`ifdef ICACHE_PREFETCH_EN
  logic [63:0] pf_addr;
  assign pf_addr = miss_addr_q + 64'd8;
`endif

  always_comb begin
    state_d               = state_q;
    miss_addr_d           = miss_addr_q;
    pend_tag_d            = pend_tag_q;
    bus.Icache_valid_out  = bus.cache_rd_valid;
    bus.Icache_data_out   = bus.cache_rd_data;
    bus.cache_wr_en       = 1'b0;
    bus.cache_wr_idx      = miss_addr_q[3 +: INDEX_W];
    bus.cache_wr_tag      = miss_addr_q[3 + INDEX_W +: TAG_W];
    bus.cache_wr_data     = bus.Imem2proc_data;
    bus.proc2Imem_command = BusNone;
    bus.proc2Imem_addr    = '0;

    if (!reset) begin
      case (state_q)
        StIdle: begin
          if (!bus.cache_rd_valid) begin
            bus.proc2Imem_command = BusLoad;
            bus.proc2Imem_addr    = pc_line;
            if (bus.Imem2proc_response != '0) begin
              pend_tag_d  = bus.Imem2proc_response;
              miss_addr_d = pc_line;
              state_d     = StWait;
            end
          end
        end
        StWait: begin
          if (fill_hit) begin
            bus.cache_wr_en = 1'b1;
            if (fwd) begin
              bus.Icache_valid_out = 1'b1;
              bus.Icache_data_out  = bus.Imem2proc_data;
            end
`ifdef ICACHE_PREFETCH_EN
            state_d = StPfReq;
`else
            state_d = StIdle;
`endif
          end
        end
`ifdef ICACHE_PREFETCH_EN
        StPfReq: begin
          bus.proc2Imem_command = BusLoad;
          if (!bus.cache_rd_valid) begin
            // Demand miss wins; an unaccepted demand retries from IDLE.
            bus.proc2Imem_addr = pc_line;
            if (bus.Imem2proc_response != '0) begin
              pend_tag_d  = bus.Imem2proc_response;
              miss_addr_d = pc_line;
              state_d     = StWait;
            end else begin
              state_d = StIdle;
            end
          end else begin
            bus.proc2Imem_addr = pf_addr;
            if (bus.Imem2proc_response != '0) begin
              pend_tag_d  = bus.Imem2proc_response;
              miss_addr_d = pf_addr;
              state_d     = StPfWait;
            end
          end
        end
        StPfWait: begin
          if (fill_hit) begin
            bus.cache_wr_en = 1'b1;
            if (fwd) begin
              bus.Icache_valid_out = 1'b1;
              bus.Icache_data_out  = bus.Imem2proc_data;
            end
            state_d = StIdle;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      miss_addr_q <= '0;
      pend_tag_q  <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      pend_tag_q  <= pend_tag_d;
    end
  end

endmodule
